cv32e40x_instr_realigner: RTL

- Sits directly upstream of the compressed decoder, between the fetch response path and IF-stage decode.
- Accepts word-aligned 32-bit fetch responses and emits one instruction per handshake.
- Output is either a 16-bit compressed instruction zero-extended in bits [15:0], or a 32-bit instruction that may straddle two fetched words.
- Tracks the instruction PC and handles halfword-aligned branch targets.

---
 rtl/cv32e40x_pkg.sv | 18 +
 rtl/cv32e40x_instr_realigner.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared types and constants for the instruction realigner
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    WAIT_FLUSH = 2'd0,
    ALIGNED    = 2'd1,
    RESIDUAL   = 2'd2,
    SKIP_HALF  = 2'd3
  } realign_state_e;

  localparam int unsigned PC_INC_C = 2;
  localparam int unsigned PC_INC_W = 4;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/cv32e40x_instr_realigner.sv
// rtl/cv32e40x_instr_realigner.sv - splits word-aligned fetch data into 16/32-bit instructions
// Holds the upper halfword of the last fetched word so straddling 32-bit instructions can be rebuilt.
module cv32e40x_instr_realigner
  import cv32e40x_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_addr_i,
  input  logic                  fetch_valid_i,
  output logic                  fetch_ready_o,
  input  logic [31:0]           fetch_rdata_i,
  input  logic                  fetch_err_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_rdata_o,
  output logic                  out_err_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_is_compressed_o
);

  realign_state_e        state_q, state_d;
  logic [15:0]           resid_q, resid_d;
  logic                  resid_err_q, resid_err_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic        fetch_ready;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        out_c;

  always_comb begin
    state_d     = state_q;
    resid_d     = resid_q;
    resid_err_d = resid_err_q;
    pc_d        = pc_q;
    fetch_ready = 1'b0;
    out_valid   = 1'b0;
    out_rdata   = 32'h0;
    out_err     = 1'b0;
    out_c       = 1'b0;

    case (state_q)
      SKIP_HALF: begin
        fetch_ready = 1'b1;
        if (fetch_valid_i) begin
          resid_d     = fetch_rdata_i[31:16];
          resid_err_d = fetch_err_i;
          state_d     = RESIDUAL;
        end
      end
      ALIGNED: begin
        out_valid   = fetch_valid_i;
        fetch_ready = out_ready_i;
        out_err     = fetch_err_i;
        if (is_compressed(fetch_rdata_i[15:0])) begin
          out_rdata = {16'h0, fetch_rdata_i[15:0]};
          out_c     = 1'b1;
          if (fetch_valid_i && out_ready_i) begin
            resid_d     = fetch_rdata_i[31:16];
            resid_err_d = fetch_err_i;
            state_d     = RESIDUAL;
            pc_d        = pc_q + ADDR_WIDTH'(PC_INC_C);
          end
        end else begin
          out_rdata = fetch_rdata_i;
          if (fetch_valid_i && out_ready_i) begin
            pc_d = pc_q + ADDR_WIDTH'(PC_INC_W);
          end
        end
      end
      RESIDUAL: begin
        if (is_compressed(resid_q)) begin
          // Residual compressed instruction drains without consuming a fetch word.
          out_rdata = {16'h0, resid_q};
          out_err   = resid_err_q;
          out_valid = 1'b1;
          out_c     = 1'b1;
          if (out_ready_i) begin
            pc_d    = pc_q + ADDR_WIDTH'(PC_INC_C);
            state_d = ALIGNED;
          end
        end else begin
          out_rdata   = {fetch_rdata_i[15:0], resid_q};
          out_err     = resid_err_q | fetch_err_i;
          out_valid   = fetch_valid_i;
          fetch_ready = out_ready_i;
          if (fetch_valid_i && out_ready_i) begin
            resid_d     = fetch_rdata_i[31:16];
            resid_err_d = fetch_err_i;
            pc_d        = pc_q + ADDR_WIDTH'(PC_INC_W);
          end
        end
      end
      default: ;
    endcase

    // A faulting instruction parks the block until the controller redirects it.
    if (out_valid && out_ready_i && out_err) begin
      state_d = WAIT_FLUSH;
    end

    if (flush_i) begin
      fetch_ready = 1'b0;
      out_valid   = 1'b0;
      pc_d        = flush_addr_i & ~ADDR_WIDTH'(1);
      resid_err_d = 1'b0;
      state_d     = flush_addr_i[1] ? SKIP_HALF : ALIGNED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_FLUSH;
      resid_q     <= 16'h0;
      resid_err_q <= 1'b0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      resid_q     <= resid_d;
      resid_err_q <= resid_err_d;
      pc_q        <= pc_d;
    end
  end

  always_comb begin
    fetch_ready_o       = rst ? 1'b0 : fetch_ready;
    out_valid_o         = rst ? 1'b0 : out_valid;
    out_rdata_o         = rst ? 32'h0 : out_rdata;
    out_err_o           = rst ? 1'b0 : out_err;
    out_addr_o          = rst ? '0 : pc_q;
    out_is_compressed_o = rst ? 1'b0 : out_c;
  end

endmodule
